sync_fifo_fwft: RTL and testbench

// - Single-clock, parametrised FIFO; next generation of the dual-clock FIFO for same-domain buffering (MAC/switch datapath queues).
// - Adds occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
// - Adds a compile-time first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo_fwft_pkg.sv | 17 +
 rtl/sync_fifo_fwft_ram.sv | 29 ++
 rtl/sync_fifo_fwft.sv | 167 ++++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants and the clog2 helper for the sync_fifo_fwft block.
// No ports; imported by sync_fifo_fwft.
package sync_fifo_fwft_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 512;
  localparam int DEF_AEMPTY   = 4;
  localparam int AFULL_MARGIN = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Ports: clk, rst_n (read register only), we/waddr/wdata, re/raddr/rdata.
module sync_fifo_fwft_ram #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its value between reads
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with count, almost flags, sticky error flags.
// Ports: CLK, RST_N (sync, low), WR_DATA/WR_EN/WR_FULL/WR_AFULL,
//   RD_EN/RD_DATA/RD_VALID/RD_EMPTY/RD_AEMPTY, COUNT, OVERFLOW, UNDERFLOW.
// Macro SYNC_FIFO_FWFT_EN builds first-word-fall-through read mode.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int C_WIDTH         = DEF_WIDTH,
  parameter int C_DEPTH         = DEF_DEPTH,
  parameter int C_AFULL_THRESH  = (1 << clog2(C_DEPTH)) - AFULL_MARGIN,
  parameter int C_AEMPTY_THRESH = DEF_AEMPTY,
  localparam int C_REAL_DEPTH   = 1 << clog2(C_DEPTH),
  localparam int C_DEPTH_BITS   = clog2(C_REAL_DEPTH),
  localparam int C_COUNT_BITS   = clog2(C_REAL_DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [C_WIDTH-1:0]      WR_DATA,
  input  logic                    WR_EN,
  output logic                    WR_FULL,
  output logic                    WR_AFULL,
  input  logic                    RD_EN,
  output logic [C_WIDTH-1:0]      RD_DATA,
  output logic                    RD_VALID,
  output logic                    RD_EMPTY,
  output logic                    RD_AEMPTY,
  output logic [C_COUNT_BITS-1:0] COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int PW = C_DEPTH_BITS + 1;
  localparam int CB = C_COUNT_BITS;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CB-1:0] CNT_ONE = CB'(1);
  localparam logic [CB-1:0] CNT_MAX = CB'(C_REAL_DEPTH);
  localparam logic [CB-1:0] AF_LVL  = CB'(C_AFULL_THRESH);
  localparam logic [CB-1:0] AE_LVL  = CB'(C_AEMPTY_THRESH);

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW-1:0]      wr_ptr_d, rd_ptr_d;
  logic [CB-1:0]      count_q, count_d;
  logic               full_q, afull_q;
  logic               empty_q, aempty_q;
  logic               ovf_q, unf_q;
  logic               full_d, empty_d;
  logic               wr_acc, rd_acc;
  logic               ram_rd;
  logic [C_WIDTH-1:0] ram_q;

  assign wr_acc = WR_EN & ~full_q;
  assign rd_acc = RD_EN & ~empty_q;

`ifdef SYNC_FIFO_FWFT_EN
  // RAM read register acts as a middle stage; out_q is the
  // prefetch register that presents the head word.
  logic               mid_v, out_v;
  logic               mid_v_d, out_v_d;
  logic               out_ld;
  logic [C_WIDTH-1:0] out_q;

  always_comb begin
    out_ld  = mid_v & (~out_v | rd_acc);
    ram_rd  = (wr_ptr != rd_ptr) & (~mid_v | out_ld);
    mid_v_d = ram_rd | (mid_v & ~out_ld);
    out_v_d = out_ld | (out_v & ~rd_acc);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mid_v <= 1'b0;
      out_v <= 1'b0;
      out_q <= '0;
    end else begin
      mid_v <= mid_v_d;
      out_v <= out_v_d;
      if (out_ld) out_q <= ram_q;
    end
  end

  // Words in flight count toward capacity, so full
  // comes from COUNT rather than the RAM pointers.
  assign full_d   = (count_d == CNT_MAX);
  assign empty_d  = ~out_v_d;
  assign RD_DATA  = out_q;
  assign RD_VALID = out_v;
`else
  logic rv_q;

  assign ram_rd = rd_acc;

  always_ff @(posedge CLK) begin
    if (!RST_N) rv_q <= 1'b0;
    else rv_q <= rd_acc;
  end

  assign full_d  = (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]) &&
                   (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]);
  assign empty_d  = (wr_ptr_d == rd_ptr_d);
  assign RD_DATA  = ram_q;
  assign RD_VALID = rv_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    if (wr_acc) wr_ptr_d = wr_ptr + PTR_ONE;
    if (ram_rd) rd_ptr_d = rd_ptr + PTR_ONE;
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      afull_q  <= (count_d >= AF_LVL);
      empty_q  <= empty_d;
      aempty_q <= (count_d <= AE_LVL);
      ovf_q    <= ovf_q | (WR_EN & full_q);
      unf_q    <= unf_q | (RD_EN & empty_q);
    end
  end

  sync_fifo_fwft_ram #(
    .W  (C_WIDTH),
    .AW (C_DEPTH_BITS)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (wr_acc),
    .waddr (wr_ptr[PW-2:0]),
    .wdata (WR_DATA),
    .re    (ram_rd),
    .raddr (rd_ptr[PW-2:0]),
    .rdata (ram_q)
  );

  assign WR_FULL   = full_q;
  assign WR_AFULL  = afull_q;
  assign RD_EMPTY  = empty_q;
  assign RD_AEMPTY = aempty_q;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft (depth 8, thresholds 6/2).
// Covers both builds selected by SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_fwft;

  localparam int W  = 8;
  localparam int CB = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          WR_EN = 1'b0;
  logic          RD_EN = 1'b0;
  logic [W-1:0]  WR_DATA = '0;
  logic [W-1:0]  RD_DATA;
  logic          WR_FULL, WR_AFULL;
  logic          RD_VALID, RD_EMPTY, RD_AEMPTY;
  logic          OVERFLOW, UNDERFLOW;
  logic [CB-1:0] COUNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sync_fifo_fwft #(
    .C_WIDTH         (W),
    .C_DEPTH         (8),
    .C_AFULL_THRESH  (6),
    .C_AEMPTY_THRESH (2)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WR_DATA   (WR_DATA),
    .WR_EN     (WR_EN),
    .WR_FULL   (WR_FULL),
    .WR_AFULL  (WR_AFULL),
    .RD_EN     (RD_EN),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .RD_EMPTY  (RD_EMPTY),
    .RD_AEMPTY (RD_AEMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  typedef struct {
    logic          rst_n, wr, rd;
    logic [W-1:0]  wd;
    logic [CB-1:0] cnt;
    logic          full, empty, afull, aempty;
    logic          valid, ovf, unf, chk_d;
    logic [W-1:0]  data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rs, wr, rd, wd, cnt,
                              fl, em, af, ae, va, ov, un,
                              cd, dt);
    vec_t v;
    v.rst_n = rs[0];
    v.wr    = wr[0];
    v.rd    = rd[0];
    v.wd    = W'(wd);
    v.cnt   = CB'(cnt);
    v.full  = fl[0];
    v.empty = em[0];
    v.afull = af[0];
    v.aempty = ae[0];
    v.valid = va[0];
    v.ovf   = ov[0];
    v.unf   = un[0];
    v.chk_d = cd[0];
    v.data  = W'(dt);
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    int mcount, n_wr, n_rd;
    logic w, r, wr_ok, rd_ok;

    // rs wr rd wd  cnt fl em af ae va ov un cd data
`ifdef SYNC_FIFO_FWFT_EN
    tbl.push_back(mk(0,0,0,'h00, 0,0,1,0,1,0,0,0,1,'h00));
    tbl.push_back(mk(1,1,0,'hA5, 1,0,1,0,1,0,0,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00, 1,0,1,0,1,0,0,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00, 1,0,0,0,1,1,0,0,1,'hA5));
    tbl.push_back(mk(1,1,0,'h5A, 2,0,0,0,1,1,0,0,1,'hA5));
    tbl.push_back(mk(1,0,0,'h00, 2,0,0,0,1,1,0,0,1,'hA5));
    tbl.push_back(mk(1,0,1,'h00, 1,0,0,0,1,1,0,0,1,'h5A));
    tbl.push_back(mk(1,0,1,'h00, 0,0,1,0,1,0,0,0,0,'h00));
    tbl.push_back(mk(1,0,1,'h00, 0,0,1,0,1,0,0,1,0,'h00));
    tbl.push_back(mk(1,0,0,'h00, 0,0,1,0,1,0,0,1,0,'h00));
    tbl.push_back(mk(0,1,1,'h77, 0,0,1,0,1,0,0,0,1,'h00));
`else
    tbl.push_back(mk(0,0,0,'h00, 0,0,1,0,1,0,0,0,1,'h00));
    tbl.push_back(mk(1,1,0,'h11, 1,0,0,0,1,0,0,0,0,'h00));
    tbl.push_back(mk(1,1,0,'h22, 2,0,0,0,1,0,0,0,0,'h00));
    tbl.push_back(mk(1,1,0,'h33, 3,0,0,0,0,0,0,0,0,'h00));
    tbl.push_back(mk(1,0,1,'h00, 2,0,0,0,1,1,0,0,1,'h11));
    tbl.push_back(mk(1,0,1,'h00, 1,0,0,0,1,1,0,0,1,'h22));
    tbl.push_back(mk(1,0,1,'h00, 0,0,1,0,1,1,0,0,1,'h33));
    tbl.push_back(mk(1,0,0,'h00, 0,0,1,0,1,0,0,0,1,'h33));
    tbl.push_back(mk(1,0,1,'h00, 0,0,1,0,1,0,0,1,1,'h33));
    tbl.push_back(mk(1,0,0,'h00, 0,0,1,0,1,0,0,1,0,'h00));
    tbl.push_back(mk(0,1,1,'h77, 0,0,1,0,1,0,0,0,1,'h00));
    tbl.push_back(mk(1,1,0,'h44, 1,0,0,0,1,0,0,0,0,'h00));
    tbl.push_back(mk(1,1,1,'h55, 1,0,0,0,1,1,0,0,1,'h44));
    tbl.push_back(mk(1,0,1,'h00, 0,0,1,0,1,1,0,0,1,'h55));
`endif

    foreach (tbl[i]) begin
      RST_N   = tbl[i].rst_n;
      WR_EN   = tbl[i].wr;
      RD_EN   = tbl[i].rd;
      WR_DATA = tbl[i].wd;
      step();
      chk8($sformatf("v%0d count", i), 8'(COUNT), 8'(tbl[i].cnt));
      chk1($sformatf("v%0d full", i), WR_FULL, tbl[i].full);
      chk1($sformatf("v%0d empty", i), RD_EMPTY, tbl[i].empty);
      chk1($sformatf("v%0d afull", i), WR_AFULL, tbl[i].afull);
      chk1($sformatf("v%0d aempty", i), RD_AEMPTY, tbl[i].aempty);
      chk1($sformatf("v%0d valid", i), RD_VALID, tbl[i].valid);
      chk1($sformatf("v%0d ovf", i), OVERFLOW, tbl[i].ovf);
      chk1($sformatf("v%0d unf", i), UNDERFLOW, tbl[i].unf);
      if (tbl[i].chk_d)
        chk8($sformatf("v%0d data", i), RD_DATA, tbl[i].data);
    end
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    RST_N = 1'b1;

    // Fill past capacity: 9 back-to-back writes
    do_reset();
    for (int i = 0; i < 9; i++) begin
      WR_EN   = 1'b1;
      WR_DATA = W'(8'h80 + i);
      step();
      if (i == 4) chk1("fill afull@5", WR_AFULL, 1'b0);
      if (i == 5) chk1("fill afull@6", WR_AFULL, 1'b1);
      if (i == 6) chk1("fill full@7", WR_FULL, 1'b0);
      if (i == 7) chk1("fill full@8", WR_FULL, 1'b1);
    end
    WR_EN = 1'b0;
    chk8("fill count", 8'(COUNT), 8'd8);
    chk1("fill ovf", OVERFLOW, 1'b1);
    chk1("fill full", WR_FULL, 1'b1);

    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      RD_EN = 1'b0;
      for (int k = 0; k < 4 && RD_EMPTY; k++) step();
      chk1($sformatf("drain%0d valid", i), RD_VALID, 1'b1);
      chk8($sformatf("drain%0d data", i), RD_DATA, W'(8'h80 + i));
      RD_EN = 1'b1;
      step();
`else
      RD_EN = 1'b1;
      step();
      chk1($sformatf("drain%0d valid", i), RD_VALID, 1'b1);
      chk8($sformatf("drain%0d data", i), RD_DATA, W'(8'h80 + i));
`endif
    end
    RD_EN = 1'b0;
    chk1("drain empty", RD_EMPTY, 1'b1);
    chk8("drain count", 8'(COUNT), 8'd0);

    // Reset while holding 5 words discards them
    do_reset();
    for (int i = 0; i < 5; i++) begin
      WR_EN   = 1'b1;
      WR_DATA = W'(8'h90 + i);
      step();
    end
    WR_EN = 1'b0;
    step();
    step();
    step();
    chk8("hold5 count", 8'(COUNT), 8'd5);
    RST_N = 1'b0;
    step();
    chk8("rst5 count", 8'(COUNT), 8'd0);
    chk1("rst5 empty", RD_EMPTY, 1'b1);
    chk1("rst5 valid", RD_VALID, 1'b0);
    RST_N = 1'b1;
    step();
    step();
    chk8("post count", 8'(COUNT), 8'd0);
    chk1("post empty", RD_EMPTY, 1'b1);

    // Random stream of 20 words across pointer wrap
    do_reset();
    mcount = 0;
    n_wr = 0;
    n_rd = 0;
    for (int cyc = 0; cyc < 400 && n_rd < 20; cyc++) begin
      w = (n_wr < 20) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      wr_ok = w && (mcount < 8);
`ifdef SYNC_FIFO_FWFT_EN
      r = r && !RD_EMPTY;
      rd_ok = r;
      if (rd_ok) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream pop: DUT non-empty, model empty");
          rd_ok = 1'b0;
        end else begin
          chk8($sformatf("stream data%0d", n_rd), RD_DATA, q[0]);
        end
      end
`else
      rd_ok = r && (mcount > 0);
`endif
      WR_EN   = w;
      RD_EN   = r;
      WR_DATA = W'(8'hC0 + n_wr);
      step();
      if (wr_ok) begin
        q.push_back(W'(8'hC0 + n_wr));
        n_wr++;
        mcount++;
      end
      if (rd_ok) begin
        exp_d = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
        chk1($sformatf("stream valid%0d", n_rd), RD_VALID, 1'b1);
        chk8($sformatf("stream data%0d", n_rd), RD_DATA, exp_d);
`endif
        n_rd++;
        mcount--;
      end
      chk8($sformatf("stream count c%0d", cyc), 8'(COUNT), 8'(mcount));
    end
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    chk8("stream done", 8'(n_rd), 8'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
